// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall/flush controller.
// Optional feature macro: PIPE_CTRL_PERF_EN (adds stall/flush performance counters).
package pipe_hazard_ctrl_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned PERF_W     = 32;

    // Controller states
    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_REDIR = 2'd1,
        CTRL_MWAIT = 2'd2
    } ctrl_state_e;

    // Stall/flush/redirect control bundle driven towards the pipeline registers
    typedef struct packed {
        logic pc_stall;
        logic regD_stall;
        logic regE_stall;
        logic regM_stall;
        logic regD_flush;
        logic regE_flush;
        logic regW_flush;
        logic redirect;
    } ctrl_bus_t;

    // Width of the memory-wait counter: enough bits to hold MEM_TIMEOUT itself
    function automatic int unsigned wait_cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator: a load in execute feeds a register read in decode.
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] dec_i_rs1,
    input  logic [REG_ADDR_W-1:0] dec_i_rs2,
    input  logic                  dec_i_rs1_ren,
    input  logic                  dec_i_rs2_ren,
    input  logic                  regE_i_mem_ren,
    input  logic                  regE_i_wb_reg_wen,
    input  logic [REG_ADDR_W-1:0] regE_i_wb_rd,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;
    logic load_writes;

    // x0 never carries a value, so a load targeting it cannot create a hazard
    always_comb begin
        load_writes = regE_i_mem_ren & regE_i_wb_reg_wen & (regE_i_wb_rd != '0);
        rs1_hit     = dec_i_rs1_ren & (dec_i_rs1 == regE_i_wb_rd);
        rs2_hit     = dec_i_rs2_ren & (dec_i_rs2 == regE_i_wb_rd);
        load_use    = load_writes & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: load-use stall, memory-wait hold, mispredict redirect with
// a two-cycle wrong-path flush, and a sticky memory-timeout flag.
// Optional feature macro: PIPE_CTRL_PERF_EN (stall/flush performance counters).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] dec_i_rs1,
    input  logic [REG_ADDR_W-1:0] dec_i_rs2,
    input  logic                  dec_i_rs1_ren,
    input  logic                  dec_i_rs2_ren,
    input  logic                  regE_i_mem_ren,
    input  logic                  regE_i_wb_reg_wen,
    input  logic [REG_ADDR_W-1:0] regE_i_wb_rd,
    input  logic                  exe_i_mispredict,
    input  logic [XLEN-1:0]       exe_i_target,
    input  logic                  mem_i_req,
    input  logic                  mem_i_ack,
    output logic                  ctrl_o_pc_stall,
    output logic                  ctrl_o_regD_stall,
    output logic                  ctrl_o_regE_stall,
    output logic                  ctrl_o_regM_stall,
    output logic                  ctrl_o_regD_flush,
    output logic                  ctrl_o_regE_flush,
    output logic                  ctrl_o_regW_flush,
    output logic                  ctrl_o_redirect,
    output logic [XLEN-1:0]       ctrl_o_redirect_pc,
    output logic                  ctrl_o_mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]     ctrl_o_stall_cnt,
    output logic [PERF_W-1:0]     ctrl_o_flush_cnt
`endif
);

    localparam int unsigned         WAIT_W   = wait_cnt_width(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    ctrl_state_e       state;
    ctrl_state_e       state_nxt;
    logic [XLEN-1:0]   redir_pc;
    logic              pending;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              mem_timeout;

    logic              memstall;
    logic              load_use;
    logic              do_redirect;
    logic              run_eval;
    logic              take_mispredict;
    logic              take_load_use;
    ctrl_bus_t         ctrl;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .dec_i_rs1         (dec_i_rs1),
        .dec_i_rs2         (dec_i_rs2),
        .dec_i_rs1_ren     (dec_i_rs1_ren),
        .dec_i_rs2_ren     (dec_i_rs2_ren),
        .regE_i_mem_ren    (regE_i_mem_ren),
        .regE_i_wb_reg_wen (regE_i_wb_reg_wen),
        .regE_i_wb_rd      (regE_i_wb_rd),
        .load_use          (load_use)
    );

    // Decision terms; memstall overrides everything, a pending redirect beats the RUN rules
    always_comb begin
        memstall        = mem_i_req & ~mem_i_ack;
        do_redirect     = ~memstall & ((state == CTRL_REDIR) | ((state == CTRL_MWAIT) & pending));
        run_eval        = ~memstall & ((state == CTRL_RUN)   | ((state == CTRL_MWAIT) & ~pending));
        take_mispredict = run_eval & exe_i_mispredict;
        take_load_use   = run_eval & ~exe_i_mispredict & load_use;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CTRL_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = CTRL_RUN;
        if (memstall) begin
            state_nxt = CTRL_MWAIT;
        end else if (take_mispredict) begin
            state_nxt = CTRL_REDIR;
        end
    end

    // Output decode: stall/flush controls and redirect strobe
    always_comb begin
        ctrl = '0;
        if (memstall) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.regD_stall = 1'b1;
            ctrl.regE_stall = 1'b1;
            ctrl.regM_stall = 1'b1;
            ctrl.regW_flush = 1'b1;
        end else if (do_redirect) begin
            ctrl.redirect   = 1'b1;
            ctrl.regD_flush = 1'b1;
            ctrl.regE_flush = 1'b1;
        end else if (take_mispredict) begin
            ctrl.regD_flush = 1'b1;
            ctrl.regE_flush = 1'b1;
        end else if (take_load_use) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.regD_stall = 1'b1;
            ctrl.regE_flush = 1'b1;
        end
    end

    // Wait counter counts consecutive stalled cycles, saturating at the timeout
    always_comb begin
        wait_cnt_nxt = '0;
        if (memstall) begin
            wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
    end

    // Redirect target, pending-redirect, wait counter and sticky timeout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_pc    <= '0;
            pending     <= 1'b0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (take_mispredict) begin
                redir_pc <= exe_i_target;
            end
            if (memstall && (state == CTRL_REDIR)) begin
                pending <= 1'b1;
            end else if (do_redirect) begin
                pending <= 1'b0;
            end
            wait_cnt <= wait_cnt_nxt;
            if (memstall && (wait_cnt_nxt == WAIT_MAX)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    assign ctrl_o_pc_stall    = ctrl.pc_stall;
    assign ctrl_o_regD_stall  = ctrl.regD_stall;
    assign ctrl_o_regE_stall  = ctrl.regE_stall;
    assign ctrl_o_regM_stall  = ctrl.regM_stall;
    assign ctrl_o_regD_flush  = ctrl.regD_flush;
    assign ctrl_o_regE_flush  = ctrl.regE_flush;
    assign ctrl_o_regW_flush  = ctrl.regW_flush;
    assign ctrl_o_redirect    = ctrl.redirect;
    assign ctrl_o_redirect_pc = redir_pc;
    assign ctrl_o_mem_timeout = mem_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    // Performance counters: PC-stall cycles and issued redirects, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctrl.pc_stall) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (ctrl.redirect) begin
                flush_cnt <= flush_cnt + PERF_W'(1);
            end
        end
    end

    assign ctrl_o_stall_cnt = stall_cnt;
    assign ctrl_o_flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized
// run against a behavioural model. Honors PIPE_CTRL_PERF_EN when defined.
module tb_pipe_hazard_ctrl;

    localparam int unsigned T = 4;

    // Expected-vector bit order: {pc_st, D_st, E_st, M_st, D_fl, E_fl, W_fl, redirect, timeout}
    localparam logic [8:0] E_IDLE  = 9'b000000000;
    localparam logic [8:0] E_STALL = 9'b111100100;
    localparam logic [8:0] E_LU    = 9'b110001000;
    localparam logic [8:0] E_MISP  = 9'b000011000;
    localparam logic [8:0] E_REDIR = 9'b000011010;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  dec_i_rs1, dec_i_rs2;
    logic        dec_i_rs1_ren, dec_i_rs2_ren;
    logic        regE_i_mem_ren, regE_i_wb_reg_wen;
    logic [4:0]  regE_i_wb_rd;
    logic        exe_i_mispredict;
    logic [63:0] exe_i_target;
    logic        mem_i_req, mem_i_ack;
    logic        ctrl_o_pc_stall, ctrl_o_regD_stall, ctrl_o_regE_stall, ctrl_o_regM_stall;
    logic        ctrl_o_regD_flush, ctrl_o_regE_flush, ctrl_o_regW_flush;
    logic        ctrl_o_redirect, ctrl_o_mem_timeout;
    logic [63:0] ctrl_o_redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] ctrl_o_stall_cnt, ctrl_o_flush_cnt;
`endif

    logic [8:0] act;
    int checks   = 0;
    int failures = 0;

    // Reference model state: an owed redirect and its target, stall run length, sticky timeout
    bit          m_owed;
    logic [63:0] m_pc;
    int unsigned m_cnt;
    bit          m_to;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] m_scnt, m_fcnt;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk                (clk),
        .rst                (rst),
        .dec_i_rs1          (dec_i_rs1),
        .dec_i_rs2          (dec_i_rs2),
        .dec_i_rs1_ren      (dec_i_rs1_ren),
        .dec_i_rs2_ren      (dec_i_rs2_ren),
        .regE_i_mem_ren     (regE_i_mem_ren),
        .regE_i_wb_reg_wen  (regE_i_wb_reg_wen),
        .regE_i_wb_rd       (regE_i_wb_rd),
        .exe_i_mispredict   (exe_i_mispredict),
        .exe_i_target       (exe_i_target),
        .mem_i_req          (mem_i_req),
        .mem_i_ack          (mem_i_ack),
        .ctrl_o_pc_stall    (ctrl_o_pc_stall),
        .ctrl_o_regD_stall  (ctrl_o_regD_stall),
        .ctrl_o_regE_stall  (ctrl_o_regE_stall),
        .ctrl_o_regM_stall  (ctrl_o_regM_stall),
        .ctrl_o_regD_flush  (ctrl_o_regD_flush),
        .ctrl_o_regE_flush  (ctrl_o_regE_flush),
        .ctrl_o_regW_flush  (ctrl_o_regW_flush),
        .ctrl_o_redirect    (ctrl_o_redirect),
        .ctrl_o_redirect_pc (ctrl_o_redirect_pc),
        .ctrl_o_mem_timeout (ctrl_o_mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .ctrl_o_stall_cnt   (ctrl_o_stall_cnt),
        .ctrl_o_flush_cnt   (ctrl_o_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign act = {ctrl_o_pc_stall, ctrl_o_regD_stall, ctrl_o_regE_stall, ctrl_o_regM_stall,
                  ctrl_o_regD_flush, ctrl_o_regE_flush, ctrl_o_regW_flush,
                  ctrl_o_redirect, ctrl_o_mem_timeout};

    function automatic bit model_lu();
        return regE_i_mem_ren && regE_i_wb_reg_wen && (regE_i_wb_rd != 5'd0) &&
               ((dec_i_rs1_ren && dec_i_rs1 == regE_i_wb_rd) ||
                (dec_i_rs2_ren && dec_i_rs2 == regE_i_wb_rd));
    endfunction

    // Expected controls for the current inputs, from the owed-redirect view of the pipeline
    function automatic logic [8:0] model_exp();
        logic [8:0] e;
        if (mem_i_req && !mem_i_ack) e = E_STALL;
        else if (m_owed)             e = E_REDIR;
        else if (exe_i_mispredict)   e = E_MISP;
        else if (model_lu())         e = E_LU;
        else                         e = E_IDLE;
        e[0] = m_to;
        return e;
    endfunction

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_commit();
        if (rst) begin
            m_owed = 1'b0; m_pc = '0; m_cnt = 0; m_to = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
            m_scnt = '0; m_fcnt = '0;
`endif
        end else if (mem_i_req && !mem_i_ack) begin
            if (m_cnt < T) m_cnt = m_cnt + 1;
            if (m_cnt == T) m_to = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
            m_scnt = m_scnt + 32'd1;
`endif
        end else begin
            m_cnt = 0;
            if (m_owed) begin
                m_owed = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
                m_fcnt = m_fcnt + 32'd1;
`endif
            end else if (exe_i_mispredict) begin
                m_owed = 1'b1;
                m_pc   = exe_i_target;
            end else if (model_lu()) begin
`ifdef PIPE_CTRL_PERF_EN
                m_scnt = m_scnt + 32'd1;
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_idle();
        dec_i_rs1 = 5'd0; dec_i_rs2 = 5'd0; dec_i_rs1_ren = 1'b0; dec_i_rs2_ren = 1'b0;
        regE_i_mem_ren = 1'b0; regE_i_wb_reg_wen = 1'b0; regE_i_wb_rd = 5'd0;
        exe_i_mispredict = 1'b0; exe_i_target = '0; mem_i_req = 1'b0; mem_i_ack = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (act !== E_IDLE) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected %b", act, E_IDLE);
        end
        checks++;
        if (ctrl_o_redirect_pc !== 64'd0) begin
            failures++;
            $display("FAIL reset_pc: got %h expected 0", ctrl_o_redirect_pc);
        end
        tick();
    endtask

    task automatic test_load_use();
        // {mem_ren, rd, rs1, rs1_ren, rs2, rs2_ren, expected}
        logic [20:0] vec [6];
        vec[0] = {1'b1, 5'd5, 5'd5, 1'b1, 5'd9, 1'b1, 3'd1};
        vec[1] = {1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 3'd0};
        vec[2] = {1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 3'd1};
        vec[3] = {1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 3'd0};
        vec[4] = {1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 3'd0};
        vec[5] = {1'b1, 5'd31, 5'd31, 1'b0, 5'd30, 1'b1, 3'd0};
        for (int i = 0; i < 6; i++) begin
            logic [20:0] v;
            logic [8:0]  exp_v;
            v = vec[i];
            set_idle();
            regE_i_mem_ren = v[20]; regE_i_wb_reg_wen = 1'b1; regE_i_wb_rd = v[19:15];
            dec_i_rs1 = v[14:10]; dec_i_rs1_ren = v[9];
            dec_i_rs2 = v[8:4];   dec_i_rs2_ren = v[3];
            exp_v = v[0] ? E_LU : E_IDLE;
            @(negedge clk);
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, act, exp_v);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_mispredict();
        set_idle();
        exe_i_mispredict = 1'b1; exe_i_target = 64'h8000_0040;
        @(negedge clk);
        checks++;
        if (act !== E_MISP) begin
            failures++;
            $display("FAIL misp_n: got %b expected %b", act, E_MISP);
        end
        tick();
        // Redirect cycle: a fresh mispredict and a load-use are both ignored
        exe_i_target = 64'hdead_beef_0000_0000;
        regE_i_mem_ren = 1'b1; regE_i_wb_reg_wen = 1'b1; regE_i_wb_rd = 5'd4;
        dec_i_rs1 = 5'd4; dec_i_rs1_ren = 1'b1;
        @(negedge clk);
        checks++;
        if (act !== E_REDIR || ctrl_o_redirect_pc !== 64'h8000_0040) begin
            failures++;
            $display("FAIL misp_n1: got %b pc %h expected %b pc 80000040", act, ctrl_o_redirect_pc, E_REDIR);
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (act !== E_IDLE || ctrl_o_redirect_pc !== 64'h8000_0040) begin
            failures++;
            $display("FAIL misp_n2: got %b pc %h expected %b pc 80000040", act, ctrl_o_redirect_pc, E_IDLE);
        end
        tick();
    endtask

    task automatic test_memstall();
        set_idle();
        mem_i_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [8:0] exp_v;
            mem_i_ack = (i == 3);
            exp_v = (i == 3) ? E_IDLE : E_STALL;
            @(negedge clk);
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL memstall[%0d]: got %b expected %b", i, act, exp_v);
            end
            tick();
        end
        // req with ack in the same cycle is not a stall
        @(negedge clk);
        checks++;
        if (act !== E_IDLE) begin
            failures++;
            $display("FAIL req_ack_same: got %b expected %b", act, E_IDLE);
        end
        tick();
        set_idle();
    endtask

    task automatic test_mispredict_then_stall();
        // {req, ack, misp, target, expected, expected pc (0 = skip)}
        logic [8:0]  exp_v [9];
        logic [2:0]  ctl   [9];
        logic [63:0] tgt   [9];
        logic [63:0] pcx   [9];
        ctl[0] = 3'b001; tgt[0] = 64'h1234_5678_9abc_def0; exp_v[0] = E_MISP;  pcx[0] = '0;
        ctl[1] = 3'b101; tgt[1] = 64'h1111;                exp_v[1] = E_STALL; pcx[1] = '0;
        ctl[2] = 3'b101; tgt[2] = 64'h2222;                exp_v[2] = E_STALL; pcx[2] = '0;
        ctl[3] = 3'b110; tgt[3] = 64'h3333;                exp_v[3] = E_REDIR; pcx[3] = 64'h1234_5678_9abc_def0;
        ctl[4] = 3'b000; tgt[4] = 64'h0;                   exp_v[4] = E_IDLE;  pcx[4] = 64'h1234_5678_9abc_def0;
        ctl[5] = 3'b101; tgt[5] = 64'h4444;                exp_v[5] = E_STALL; pcx[5] = '0;
        ctl[6] = 3'b111; tgt[6] = 64'h0000_0000_8000_1000; exp_v[6] = E_MISP;  pcx[6] = '0;
        ctl[7] = 3'b000; tgt[7] = 64'h0;                   exp_v[7] = E_REDIR; pcx[7] = 64'h0000_0000_8000_1000;
        ctl[8] = 3'b000; tgt[8] = 64'h0;                   exp_v[8] = E_IDLE;  pcx[8] = '0;
        for (int i = 0; i < 9; i++) begin
            set_idle();
            mem_i_req = ctl[i][2]; mem_i_ack = ctl[i][1];
            exe_i_mispredict = ctl[i][0]; exe_i_target = tgt[i];
            @(negedge clk);
            checks++;
            if (act !== exp_v[i] || (pcx[i] != '0 && ctrl_o_redirect_pc !== pcx[i])) begin
                failures++;
                $display("FAIL misp_stall[%0d]: got %b pc %h expected %b pc %h", i, act, ctrl_o_redirect_pc, exp_v[i], pcx[i]);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_timeout();
        do_reset();
        exe_i_mispredict = 1'b1; exe_i_target = 64'hcafe_0000_0000_0100;
        tick();
        // Stall begins in the redirect cycle, so a redirect is owed throughout
        set_idle();
        mem_i_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            logic [8:0] exp_v;
            exp_v = (k >= 5) ? (E_STALL | 9'b1) : E_STALL;
            @(negedge clk);
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL timeout_stall[%0d]: got %b expected %b", k, act, exp_v);
            end
            tick();
        end
        mem_i_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (act !== (E_REDIR | 9'b1)) begin
            failures++;
            $display("FAIL timeout_sticky: got %b expected %b", act, E_REDIR | 9'b1);
        end
        // Reset while still waiting: the owed redirect and the flag both go away
        mem_i_ack = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (act !== E_IDLE || ctrl_o_redirect_pc !== 64'd0) begin
                failures++;
                $display("FAIL timeout_rst[%0d]: got %b pc %h expected %b pc 0", i, act, ctrl_o_redirect_pc, E_IDLE);
            end
            tick();
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        exe_i_mispredict = 1'b1; exe_i_target = 64'h8000_0040;
        tick();
        set_idle();
        tick();
        mem_i_req = 1'b1;
        tick(); tick(); tick();
        mem_i_ack = 1'b1;
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (ctrl_o_flush_cnt !== 32'd1 || ctrl_o_stall_cnt !== 32'd3) begin
            failures++;
            $display("FAIL perf_cnt: got flush %0d stall %0d expected flush 1 stall 3", ctrl_o_flush_cnt, ctrl_o_stall_cnt);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] exp_v;
            rst               = ($urandom_range(0, 199) == 0);
            dec_i_rs1         = 5'($urandom_range(0, 3));
            dec_i_rs2         = 5'($urandom_range(0, 3));
            dec_i_rs1_ren     = 1'($urandom_range(0, 1));
            dec_i_rs2_ren     = 1'($urandom_range(0, 1));
            regE_i_mem_ren    = ($urandom_range(0, 2) != 0);
            regE_i_wb_reg_wen = ($urandom_range(0, 3) != 0);
            regE_i_wb_rd      = 5'($urandom_range(0, 3));
            exe_i_mispredict  = ($urandom_range(0, 6) == 0);
            exe_i_target      = {$urandom, $urandom};
            mem_i_req         = ($urandom_range(0, 2) == 0);
            mem_i_ack         = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_v = model_exp();
            checks++;
            if (act !== exp_v || ctrl_o_redirect_pc !== m_pc) begin
                failures++;
                if (failures < 20)
                    $display("FAIL random[%0d]: got %b pc %h expected %b pc %h", n, act, ctrl_o_redirect_pc, exp_v, m_pc);
            end
`ifdef PIPE_CTRL_PERF_EN
            checks++;
            if (ctrl_o_stall_cnt !== m_scnt || ctrl_o_flush_cnt !== m_fcnt) begin
                failures++;
                if (failures < 20)
                    $display("FAIL random_perf[%0d]: got %0d/%0d expected %0d/%0d", n, ctrl_o_stall_cnt, ctrl_o_flush_cnt, m_scnt, m_fcnt);
            end
`endif
            tick();
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_mispredict();
        test_memstall();
        test_mispredict_then_stall();
        test_timeout();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
